// File: rtl/n64_poll_scheduler_pkg.sv
// Shared constants for the N64 poll scheduler: command bytes, FSM state
// encodings and the command-priority helper.
package n64_poll_scheduler_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_POLL   = 8'h01;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ISSUE      = 3'd1;
  localparam logic [2:0] ST_WAIT_START = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
  localparam logic [2:0] ST_EVAL       = 3'd4;

  // Returns {valid, cmd}: retry beats reset beats status beats poll.
  function automatic logic [8:0] pick_cmd(input logic       retry_v,
                                          input logic [7:0] retry_cmd,
                                          input logic       rst_pend,
                                          input logic       st_pend,
                                          input logic       poll_en);
    if (retry_v)       return {1'b1, retry_cmd};
    else if (rst_pend) return {1'b1, CMD_RESET};
    else if (st_pend)  return {1'b1, CMD_STATUS};
    else if (poll_en)  return {1'b1, CMD_POLL};
    else               return {1'b0, CMD_POLL};
  endfunction

endpackage

// File: rtl/n64_poll_scheduler_if.sv
// Link between the poll scheduler and the shared serial write/read engine.
// Handshake: the scheduler pulses cmd_begin for one cycle with cmd_byte valid;
// cmd_byte then stays stable until the scheduler returns to idle. The engine
// acknowledges by raising eng_active; the transaction completes when
// eng_active falls, and eng_error/eng_data are taken on that first low cycle.
interface n64_poll_scheduler_if;
  logic        cmd_begin;
  logic [7:0]  cmd_byte;
  logic        eng_active;
  logic        eng_error;
  logic [31:0] eng_data;

  modport master (output cmd_begin, cmd_byte,
                  input  eng_active, eng_error, eng_data);
  modport slave  (input  cmd_begin, cmd_byte,
                  output eng_active, eng_error, eng_data);
endinterface

// File: rtl/n64_tick_gen.sv
// Free-running period counter; o_tick is high while the count is zero.
module n64_tick_gen #(
  parameter int PERIOD = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);
  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] r_cnt;

  // Count 0..PERIOD-1 and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == '0);
endmodule

// File: rtl/n64_poll_scheduler.sv
// Sequences reset/status/poll commands onto the shared N64 serial engine,
// retries failed transactions and tracks controller presence and fault.
module n64_poll_scheduler
  import n64_poll_scheduler_pkg::*;
#(
  parameter int POLL_PERIOD   = 100000,
  parameter int START_TIMEOUT = 16,
  parameter int DONE_TIMEOUT  = 50000,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        polling_enable,
  input  logic                        reset_req,
  input  logic                        status_req,
  n64_poll_scheduler_if.master        eng,
  output logic [31:0]                 button_data,
  output logic [23:0]                 status_data,
  output logic                        data_valid,
  output logic                        controller_present,
  output logic                        fault,
  output logic [2:0]                  dbg_state
);
  // Timeout counter is sized for the longer (done) window and shared by both waits.
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] DONE_LAST  = TW'(DONE_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LIM  = RW'(MAX_RETRIES);

  logic          w_tick;
  logic [8:0]    w_pick;
  logic          w_issue;
  logic          w_take_rst;
  logic          w_take_st;
  logic [RW-1:0] w_retry_next;

  logic [2:0]    r_state;
  logic [TW-1:0] r_to_cnt;
  logic [RW-1:0] r_retry_cnt;
  logic          r_retry_v;
  logic [7:0]    r_retry_cmd;
  logic          r_rst_d, r_st_d, r_rst_pend, r_st_pend;
  logic [7:0]    r_cmd_byte;
  logic          r_err;
  logic [31:0]   r_data;
  logic [31:0]   r_button;
  logic [23:0]   r_status;
  logic          r_dv, r_present, r_fault;

  n64_tick_gen #(.PERIOD(POLL_PERIOD)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  assign w_pick       = pick_cmd(r_retry_v, r_retry_cmd, r_rst_pend, r_st_pend, polling_enable);
  assign w_issue      = (r_state == ST_IDLE) && w_tick && w_pick[8];
  assign w_take_rst   = w_issue && !r_retry_v && r_rst_pend;
  assign w_take_st    = w_issue && !r_retry_v && !r_rst_pend && r_st_pend;
  assign w_retry_next = r_retry_cnt + 1'b1;

  // Request edge detection; a set pending flag absorbs further edges until issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_d    <= 1'b0;
      r_st_d     <= 1'b0;
      r_rst_pend <= 1'b0;
      r_st_pend  <= 1'b0;
    end else begin
      r_rst_d <= reset_req;
      r_st_d  <= status_req;
      if (w_take_rst)                r_rst_pend <= 1'b0;
      else if (reset_req && !r_rst_d) r_rst_pend <= 1'b1;
      if (w_take_st)                 r_st_pend <= 1'b0;
      else if (status_req && !r_st_d) r_st_pend <= 1'b1;
    end
  end

  // Transaction FSM, timeouts, retry bookkeeping and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_to_cnt    <= '0;
      r_retry_cnt <= '0;
      r_retry_v   <= 1'b0;
      r_retry_cmd <= CMD_POLL;
      r_cmd_byte  <= CMD_POLL;
      r_err       <= 1'b0;
      r_data      <= '0;
      r_button    <= '0;
      r_status    <= '0;
      r_dv        <= 1'b0;
      r_present   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state    <= ST_ISSUE;
            r_cmd_byte <= w_pick[7:0];
          end
        end
        ST_ISSUE: begin
          r_state  <= ST_WAIT_START;
          r_to_cnt <= '0;
        end
        ST_WAIT_START: begin
          if (eng.eng_active) begin
            r_state  <= ST_WAIT_DONE;
            r_to_cnt <= '0;
          end else if (r_to_cnt >= START_LAST) begin
            r_state <= ST_EVAL;
            r_err   <= 1'b1;
          end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!eng.eng_active) begin
            r_state <= ST_EVAL;
            r_err   <= eng.eng_error;
            r_data  <= eng.eng_data;
          end else if (r_to_cnt >= DONE_LAST) begin
            r_state <= ST_EVAL;
            r_err   <= 1'b1;
          end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_EVAL: begin
          r_state <= ST_IDLE;
          if (!r_err) begin
            if (r_cmd_byte == CMD_POLL) r_button <= r_data;
            else                        r_status <= r_data[31:8];
            r_dv        <= 1'b1;
            r_present   <= 1'b1;
            r_fault     <= 1'b0;
            r_retry_cnt <= '0;
            r_retry_v   <= 1'b0;
          end else if (w_retry_next < RETRY_LIM) begin
            r_retry_cnt <= w_retry_next;
            r_retry_v   <= 1'b1;
            r_retry_cmd <= r_cmd_byte;
          end else begin
            r_fault     <= 1'b1;
            r_present   <= 1'b0;
            r_retry_cnt <= '0;
            r_retry_v   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign eng.cmd_begin      = (r_state == ST_ISSUE);
  assign eng.cmd_byte       = r_cmd_byte;
  assign button_data        = r_button;
  assign status_data        = r_status;
  assign data_valid         = r_dv;
  assign controller_present = r_present;
  assign fault              = r_fault;
  assign dbg_state          = r_state;
endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Directed bench for n64_poll_scheduler with a small serial-engine model.
module tb_n64_poll_scheduler;
  import n64_poll_scheduler_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic polling_enable, reset_req, status_req;
  logic [31:0] button_data;
  logic [23:0] status_data;
  logic data_valid, controller_present, fault;
  logic [2:0] dbg_state;

  n64_poll_scheduler_if eng_if();

  n64_poll_scheduler #(
    .POLL_PERIOD(100), .START_TIMEOUT(4), .DONE_TIMEOUT(40), .MAX_RETRIES(3)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .polling_enable     (polling_enable),
    .reset_req          (reset_req),
    .status_req         (status_req),
    .eng                (eng_if),
    .button_data        (button_data),
    .status_data        (status_data),
    .data_valid         (data_valid),
    .controller_present (controller_present),
    .fault              (fault),
    .dbg_state          (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- engine model ----------------
  logic        bfm_err, bfm_nostart;
  int          bfm_len;
  logic [31:0] bfm_data;

  initial begin
    eng_if.eng_active = 1'b0;
    eng_if.eng_error  = 1'b0;
    eng_if.eng_data   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && eng_if.cmd_begin && !bfm_nostart) begin
        @(negedge clk);
        eng_if.eng_active = 1'b1;
        eng_if.eng_error  = 1'b0;
        for (int k = 0; k < bfm_len; k++) begin
          @(negedge clk);
          if (!rst_n) break;
        end
        eng_if.eng_active = 1'b0;
        eng_if.eng_error  = bfm_err;
        eng_if.eng_data   = bfm_data;
      end
    end
  end

  // ---------------- monitor ----------------
  int         begin_cnt = 0, dv_cnt = 0, ws_cnt = 0, wd_cnt = 0, begin_cyc = 0;
  logic [7:0] begin_byte;

  always @(negedge clk) begin
    if (eng_if.cmd_begin) begin
      begin_cnt++;
      begin_cyc  = cyc;
      begin_byte = eng_if.cmd_byte;
    end
    if (data_valid) dv_cnt++;
    if (dbg_state == ST_WAIT_START) ws_cnt++;
    if (dbg_state == ST_WAIT_DONE)  wd_cnt++;
  end

  // ---------------- scoreboard ----------------
  int n_total = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic pe, rreq, sreq, err, nostart;
    int len;
    logic [31:0] data;
    int exp_begin;
    logic [7:0] exp_cmd;
    int exp_dv;
    logic [31:0] exp_button;
    logic [23:0] exp_status;
    logic exp_present, exp_fault;
    int exp_ws, exp_wd;
  } vec_t;

  function automatic vec_t mk(logic pe, logic rreq, logic sreq, logic err, logic nostart,
                              int len, logic [31:0] data, int eb, logic [7:0] ec, int edv,
                              logic [31:0] ebtn, logic [23:0] est, logic epr, logic eft,
                              int ews, int ewd);
    vec_t v;
    v.pe = pe; v.rreq = rreq; v.sreq = sreq; v.err = err; v.nostart = nostart;
    v.len = len; v.data = data; v.exp_begin = eb; v.exp_cmd = ec; v.exp_dv = edv;
    v.exp_button = ebtn; v.exp_status = est; v.exp_present = epr; v.exp_fault = eft;
    v.exp_ws = ews; v.exp_wd = ewd;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_begin(input int b0, input int limit);
    for (int i = 0; i < limit && begin_cnt == b0; i++) @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int b0, d0, s0, w0;
    @(negedge clk);
    polling_enable = v.pe;
    reset_req      = v.rreq;
    status_req     = v.sreq;
    bfm_err        = v.err;
    bfm_nostart    = v.nostart;
    bfm_len        = v.len;
    bfm_data       = v.data;
    b0 = begin_cnt; d0 = dv_cnt; s0 = ws_cnt; w0 = wd_cnt;
    @(negedge clk);
    reset_req  = 1'b0;
    status_req = 1'b0;
    if (v.exp_begin != 0) begin
      wait_begin(b0, 110);
      repeat (70) @(negedge clk);
    end else begin
      repeat (100) @(negedge clk);
    end
    chk($sformatf("v%0d_begins", idx), 32'(begin_cnt - b0), 32'(v.exp_begin));
    if (v.exp_begin != 0 && begin_cnt != b0)
      chk($sformatf("v%0d_cmd_byte", idx), {24'h0, begin_byte}, {24'h0, v.exp_cmd});
    chk($sformatf("v%0d_data_valid", idx), 32'(dv_cnt - d0), 32'(v.exp_dv));
    chk($sformatf("v%0d_button", idx), button_data, v.exp_button);
    chk($sformatf("v%0d_status", idx), {8'h0, status_data}, {8'h0, v.exp_status});
    chk($sformatf("v%0d_present", idx), {31'h0, controller_present}, {31'h0, v.exp_present});
    chk($sformatf("v%0d_fault", idx), {31'h0, fault}, {31'h0, v.exp_fault});
    chk($sformatf("v%0d_wait_start_cyc", idx), 32'(ws_cnt - s0), 32'(v.exp_ws));
    chk($sformatf("v%0d_wait_done_cyc", idx), 32'(wd_cnt - w0), 32'(v.exp_wd));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_button"},  button_data, 32'h0);
    chk({tag, "_status"},  {8'h0, status_data}, 32'h0);
    chk({tag, "_dv"},      {31'h0, data_valid}, 32'h0);
    chk({tag, "_present"}, {31'h0, controller_present}, 32'h0);
    chk({tag, "_fault"},   {31'h0, fault}, 32'h0);
    chk({tag, "_begin"},   {31'h0, eng_if.cmd_begin}, 32'h0);
    chk({tag, "_cmd_byte"}, {24'h0, eng_if.cmd_byte}, 32'h01);
    chk({tag, "_state"},   {29'h0, dbg_state}, {29'h0, ST_IDLE});
  endtask

  // ---------------- test ----------------
  vec_t vecs[17];

  initial begin
    int b0, d0, rel, first;

    vecs[0]  = mk(1,0,0,0,0, 5,32'h12345601, 1,8'h01,1,32'h12345601,24'h000000,1,0,1,5);
    vecs[1]  = mk(1,1,1,0,0, 5,32'hCAFEBE00, 1,8'hFF,1,32'h12345601,24'hCAFEBE,1,0,1,5);
    vecs[2]  = mk(1,0,0,0,0, 5,32'h0505AA00, 1,8'h00,1,32'h12345601,24'h0505AA,1,0,1,5);
    vecs[3]  = mk(1,0,0,0,0, 7,32'h11112222, 1,8'h01,1,32'h11112222,24'h0505AA,1,0,1,7);
    vecs[4]  = mk(1,0,0,1,0, 5,32'hDEADBEEF, 1,8'h01,0,32'h11112222,24'h0505AA,1,0,1,5);
    vecs[5]  = mk(1,0,0,1,0, 5,32'hDEADBEEF, 1,8'h01,0,32'h11112222,24'h0505AA,1,0,1,5);
    vecs[6]  = mk(1,0,0,1,0, 5,32'hDEADBEEF, 1,8'h01,0,32'h11112222,24'h0505AA,0,1,1,5);
    vecs[7]  = mk(1,0,0,0,0, 5,32'h77770001, 1,8'h01,1,32'h77770001,24'h0505AA,1,0,1,5);
    vecs[8]  = mk(1,0,0,0,1, 5,32'h00000000, 1,8'h01,0,32'h77770001,24'h0505AA,1,0,4,0);
    vecs[9]  = mk(1,0,0,0,0,60,32'h00000000, 1,8'h01,0,32'h77770001,24'h0505AA,1,0,1,40);
    vecs[10] = mk(1,0,0,0,0, 5,32'h0A0B0C0D, 1,8'h01,1,32'h0A0B0C0D,24'h0505AA,1,0,1,5);
    vecs[11] = mk(0,0,0,0,0, 5,32'h00000000, 0,8'h00,0,32'h0A0B0C0D,24'h0505AA,1,0,0,0);
    vecs[12] = mk(0,0,1,0,0, 5,32'h99887766, 1,8'h00,1,32'h0A0B0C0D,24'h998877,1,0,1,5);
    vecs[13] = mk(0,0,0,0,0, 5,32'h00000000, 0,8'h00,0,32'h0A0B0C0D,24'h998877,1,0,0,0);
    vecs[14] = mk(1,0,0,1,0, 5,32'h55555555, 1,8'h01,0,32'h0A0B0C0D,24'h998877,1,0,1,5);
    vecs[15] = mk(1,1,0,0,0, 5,32'h31415900, 1,8'h01,1,32'h31415900,24'h998877,1,0,1,5);
    vecs[16] = mk(1,0,0,0,0, 5,32'h27182800, 1,8'hFF,1,32'h31415900,24'h271828,1,0,1,5);

    rst_n = 1'b0;
    polling_enable = 1'b1;
    reset_req = 1'b0;
    status_req = 1'b0;
    bfm_err = 1'b0;
    bfm_nostart = 1'b0;
    bfm_len = 5;
    bfm_data = 32'hA5A5_0001;

    // Power-on reset values, then first poll right at the first tick.
    repeat (3) @(negedge clk);
    chk_reset_values("por");
    rst_n = 1'b1;
    rel = cyc;
    b0 = begin_cnt;
    d0 = dv_cnt;
    wait_begin(b0, 10);
    chk("first_begin_cycle", 32'(begin_cyc), 32'(rel + 1));
    chk("first_cmd_byte", {24'h0, begin_byte}, 32'h01);
    first = begin_cyc;
    repeat (70) @(negedge clk);
    chk("first_button", button_data, 32'hA5A5_0001);
    chk("first_present", {31'h0, controller_present}, 32'h1);
    chk("first_dv_pulses", 32'(dv_cnt - d0), 32'd1);
    b0 = begin_cnt;
    wait_begin(b0, 110);
    chk("poll_period", 32'(begin_cyc - first), 32'd100);
    repeat (70) @(negedge clk);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Asynchronous reset while the engine is mid-response.
    @(negedge clk);
    polling_enable = 1'b1;
    bfm_err = 1'b0;
    bfm_nostart = 1'b0;
    bfm_len = 30;
    bfm_data = 32'h1357_2468;
    b0 = begin_cnt;
    wait_begin(b0, 110);
    for (int i = 0; i < 10 && dbg_state != ST_WAIT_DONE; i++) @(negedge clk);
    chk("mid_state_wait_done", {29'h0, dbg_state}, {29'h0, ST_WAIT_DONE});
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_values("async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    b0 = begin_cnt;
    d0 = dv_cnt;
    wait_begin(b0, 10);
    chk("rel_begin_count", 32'(begin_cnt - b0), 32'd1);
    chk("rel_begin_cycle", 32'(begin_cyc), 32'(rel + 1));
    chk("rel_cmd_byte", {24'h0, begin_byte}, 32'h01);
    repeat (70) @(negedge clk);
    chk("rel_button", button_data, 32'h1357_2468);
    chk("rel_dv_pulses", 32'(dv_cnt - d0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
